// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 8-bit LFSR stream (taps 7,5,4,3): acquires lock, then flags mispredicted words.
// Define LFSR_CHECK_PERIOD_EN to add the period measurement outputs (out_period, out_period_valid).
module lfsr_stream_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_word,
  input  logic                 in_clear,
  output logic                 out_locked,
  output logic                 out_error,
  output logic [ERR_CNT_W-1:0] out_error_count,
  output logic [1:0]           out_state
`ifdef LFSR_CHECK_PERIOD_EN
  ,
  output logic [7:0]           out_period,
  output logic                 out_period_valid
`endif
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned RUN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   expected;
  logic [RUN_W-1:0]    match_q;
  logic [RUN_W-1:0]    miss_q;

  function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] exp_next;
  logic              zero_word;
  logic              hit;
  logic              locked_miss;
  logic [RUN_W-1:0]  match_inc;
  logic [RUN_W-1:0]  miss_inc;

  assign word_next   = lfsr_next(in_word);
  assign exp_next    = lfsr_next(expected);
  assign zero_word   = (in_word == '0);
  assign hit         = (in_word == expected);
  assign locked_miss = in_valid && (state == ST_LOCKED) && (zero_word || !hit);
  assign match_inc   = match_q + RUN_W'(1);
  assign miss_inc    = miss_q + RUN_W'(1);
  assign out_state   = state;

  // Acquire/lock/loss sequencing; the prediction flywheels once locked
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state      <= ST_IDLE;
      expected   <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      out_locked <= 1'b0;
      out_error  <= 1'b0;
    end else begin
      out_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && !zero_word) begin
            expected <= word_next;
            match_q  <= '0;
            state    <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (in_valid) begin
            if (zero_word) begin
              match_q <= '0;
              state   <= ST_IDLE;
            end else if (hit) begin
              expected <= word_next;
              match_q  <= match_inc;
              if (match_inc == RUN_W'(LOCK_COUNT)) begin
                miss_q     <= '0;
                out_locked <= 1'b1;
                state      <= ST_LOCKED;
              end
            end else begin
              expected <= word_next;
              match_q  <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (in_valid) begin
            expected <= exp_next;
            if (locked_miss) begin
              out_error <= 1'b1;
              miss_q    <= miss_inc;
              if (miss_inc == RUN_W'(LOSS_COUNT)) begin
                miss_q     <= '0;
                out_locked <= 1'b0;
                state      <= ST_LOST;
              end
            end else begin
              miss_q <= '0;
            end
          end
        end
        ST_LOST: begin
          // The sample presented in this cycle is intentionally dropped
          match_q <= '0;
          state   <= ST_ACQUIRE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating error count; clear takes priority over a coincident error
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_error_count <= '0;
    end else if (in_clear) begin
      out_error_count <= '0;
    end else if (locked_miss && (out_error_count != '1)) begin
      out_error_count <= out_error_count + ERR_CNT_W'(1);
    end
  end

`ifdef LFSR_CHECK_PERIOD_EN
  logic [WORD_W-1:0] ref_word;
  logic              ref_valid;
  logic [WORD_W-1:0] period_cnt;

  // Measures samples between recurrences of the first word seen while locked
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      ref_word         <= '0;
      ref_valid        <= 1'b0;
      period_cnt       <= '0;
      out_period       <= '0;
      out_period_valid <= 1'b0;
    end else begin
      out_period_valid <= 1'b0;
      if (state != ST_LOCKED) begin
        ref_valid  <= 1'b0;
        period_cnt <= '0;
      end else if (in_valid) begin
        if (!ref_valid) begin
          ref_word   <= in_word;
          ref_valid  <= 1'b1;
          period_cnt <= '0;
        end else if (in_word == ref_word) begin
          out_period       <= period_cnt + WORD_W'(1);
          out_period_valid <= 1'b1;
          period_cnt       <= '0;
        end else begin
          period_cnt <= period_cnt + WORD_W'(1);
        end
      end
    end
  end
`endif

endmodule
